// File: rtl/combo_sweep_checker.sv
// Sweeps every WIDTH-bit vector into a combinational responder and checks that Y is high only for MATCH.
// Optional macro CHECK_STOP_ON_ERR_EN ends the sweep at the first mismatch.
module combo_sweep_checker #(
  parameter int                WIDTH  = 4,
  parameter int                SETTLE = 2,
  parameter logic [WIDTH-1:0]  MATCH  = 4'b0110
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] vec_out,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   err_count,
  output logic [WIDTH-1:0] first_err_vec,
  output logic             first_err_valid
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [3:0]       WAIT_LOAD = 4'(SETTLE - 1);
  localparam logic [WIDTH-1:0] LAST_VEC  = '1;

  state_t       state, state_next;
  logic [3:0]   wait_cnt;
  logic         sample;
  logic         mismatch;
  logic         stop_err;
  logic         sweep_end;
  logic [WIDTH:0] err_next;

  // The responder output is judged only on the last settle edge of each vector.
  always_comb begin
    sample   = (state == RUN) && (wait_cnt == 4'd0);
    mismatch = sample && (y_in != (vec_out == MATCH));
`ifdef CHECK_STOP_ON_ERR_EN
    stop_err = mismatch;
`else
    stop_err = 1'b0;
`endif
    sweep_end = sample && ((vec_out == LAST_VEC) || stop_err);
    err_next  = err_count + (WIDTH+1)'(mismatch);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)     state_next = RUN;
      RUN:     if (sweep_end) state_next = FIN;
      FIN:                    state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_out         <= '0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
      wait_cnt        <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec_out         <= '0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
            wait_cnt        <= WAIT_LOAD;
          end
        end
        RUN: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            err_count <= err_next;
            if (mismatch && !first_err_valid) begin
              first_err_vec   <= vec_out;
              first_err_valid <= 1'b1;
            end
            // The terminal vector (or a stopping mismatch) leaves vec_out parked for inspection.
            if (sweep_end) begin
              pass <= (err_next == '0);
            end else begin
              vec_out  <= vec_out + 1'b1;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_combo_sweep_checker.sv
// Scoreboard bench for combo_sweep_checker: expected sweep results are queued at start, monitors compare on done.
// Expectations follow CHECK_STOP_ON_ERR_EN when that macro is defined for the build.
module tb_combo_sweep_checker;

  typedef struct packed {
    logic       p;
    logic [4:0] err;
    logic [3:0] fvec;
    logic       fval;
    logic [3:0] vec;
    logic [7:0] busy;
  } exp_t;

  localparam exp_t E_GOOD = '{p: 1'b1, err: 5'd0, fvec: 4'd0, fval: 1'b0, vec: 4'd15, busy: 8'd32};
`ifdef CHECK_STOP_ON_ERR_EN
  localparam exp_t E_STUCK0 = '{p: 1'b0, err: 5'd1, fvec: 4'd6, fval: 1'b1, vec: 4'd6, busy: 8'd14};
  localparam exp_t E_STUCK1 = '{p: 1'b0, err: 5'd1, fvec: 4'd0, fval: 1'b1, vec: 4'd0, busy: 8'd2};
  localparam exp_t E_REG_S1 = '{p: 1'b0, err: 5'd1, fvec: 4'd6, fval: 1'b1, vec: 4'd6, busy: 8'd7};
`else
  localparam exp_t E_STUCK0 = '{p: 1'b0, err: 5'd1, fvec: 4'd6, fval: 1'b1, vec: 4'd15, busy: 8'd32};
  localparam exp_t E_STUCK1 = '{p: 1'b0, err: 5'd15, fvec: 4'd0, fval: 1'b1, vec: 4'd15, busy: 8'd32};
  localparam exp_t E_REG_S1 = '{p: 1'b0, err: 5'd2, fvec: 4'd6, fval: 1'b1, vec: 4'd15, busy: 8'd16};
`endif

  logic clk = 1'b0;
  logic rst;
  logic start0, start1;
  int   mode;   // 0 correct, 1 stuck-0, 2 stuck-1, 3 registered responder

  logic [3:0] vec0, vec1, fvec0, fvec1;
  logic [4:0] err0, err1;
  logic       y0, y1, yreg0, yreg1;
  logic       busy0, busy1, done0, done1, pass0, pass1, fval0, fval1;

  int n_cmp = 0;
  int n_err = 0;
  exp_t q0[$];
  exp_t q1[$];
  int done_seen0 = 0, done_seen1 = 0;
  int busy_cnt0 = 0, busy_cnt1 = 0;
  logic done_prev0 = 1'b0, done_prev1 = 1'b0;

  always #5 clk = ~clk;

  function automatic logic resp(input logic [3:0] v);
    return ~v[3] & v[2] & v[1] & ~v[0];
  endfunction

  always @(posedge clk) begin
    yreg0 <= resp(vec0);
    yreg1 <= resp(vec1);
  end

  always_comb begin
    case (mode)
      1:       y0 = 1'b0;
      2:       y0 = 1'b1;
      3:       y0 = yreg0;
      default: y0 = resp(vec0);
    endcase
    y1 = yreg1;
  end

  combo_sweep_checker #(.WIDTH(4), .SETTLE(2), .MATCH(4'b0110)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .vec_out(vec0), .y_in(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_err_vec(fvec0), .first_err_valid(fval0)
  );

  combo_sweep_checker #(.WIDTH(4), .SETTLE(1), .MATCH(4'b0110)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .vec_out(vec1), .y_in(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_vec(fvec1), .first_err_valid(fval1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic compare(input string tag, input exp_t e, input logic p, input logic [4:0] err,
                         input logic [3:0] fvec, input logic fval, input logic [3:0] vec, input int busy);
    check({tag, "_pass"}, 32'(p), 32'(e.p));
    check({tag, "_err_count"}, 32'(err), 32'(e.err));
    check({tag, "_first_err_vec"}, 32'(fvec), 32'(e.fvec));
    check({tag, "_first_err_valid"}, 32'(fval), 32'(e.fval));
    check({tag, "_vec_out"}, 32'(vec), 32'(e.vec));
    check({tag, "_busy_cycles"}, 32'(busy), 32'(e.busy));
  endtask

  // Monitors: count busy cycles, pop an expectation on every done pulse.
  always @(negedge clk) begin
    if (done_prev0) check("dut0_done_width", 32'(done0), 32'd0);
    done_prev0 = done0;
    if (rst) busy_cnt0 = 0;
    else begin
      if (busy0) busy_cnt0++;
      if (done0) begin
        if (q0.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL dut0_unexpected_done: got done=1, expected no done");
        end else compare("dut0", q0.pop_front(), pass0, err0, fvec0, fval0, vec0, busy_cnt0);
        busy_cnt0 = 0;
        done_seen0++;
      end
    end
  end

  always @(negedge clk) begin
    if (done_prev1) check("dut1_done_width", 32'(done1), 32'd0);
    done_prev1 = done1;
    if (rst) busy_cnt1 = 0;
    else begin
      if (busy1) busy_cnt1++;
      if (done1) begin
        if (q1.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL dut1_unexpected_done: got done=1, expected no done");
        end else compare("dut1", q1.pop_front(), pass1, err1, fvec1, fval1, vec1, busy_cnt1);
        busy_cnt1 = 0;
        done_seen1++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run0(input int m, input exp_t e);
    int s;
    mode = m;
    q0.push_back(e);
    s = done_seen0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 100 && done_seen0 == s; i++) tick();
    check("dut0_sweep_timeout", 32'(done_seen0 - s), 32'd1);
    tick();
  endtask

  task automatic check_reset0(input string tag);
    check({tag, "_vec_out"}, 32'(vec0), 32'd0);
    check({tag, "_busy"}, 32'(busy0), 32'd0);
    check({tag, "_done"}, 32'(done0), 32'd0);
    check({tag, "_pass"}, 32'(pass0), 32'd0);
    check({tag, "_err_count"}, 32'(err0), 32'd0);
    check({tag, "_first_err_vec"}, 32'(fvec0), 32'd0);
    check({tag, "_first_err_valid"}, 32'(fval0), 32'd0);
  endtask

  initial begin
    int s;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; mode = 0;
    repeat (3) tick();
    @(negedge clk);
    check_reset0("reset");
    check("reset_dut1_busy", 32'(busy1), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    run0(0, E_GOOD);      // correct responder
    run0(1, E_STUCK0);    // y stuck at 0
    run0(2, E_STUCK1);    // y stuck at 1
    run0(3, E_GOOD);      // registered responder, SETTLE=2 covers the latency

    // Registered responder on the SETTLE=1 instance lags by one vector.
    q1.push_back(E_REG_S1);
    s = done_seen1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 100 && done_seen1 == s; i++) tick();
    check("dut1_sweep_timeout", 32'(done_seen1 - s), 32'd1);
    tick();

    // Start re-pulsed mid-sweep is ignored.
    mode = 0;
    q0.push_back(E_GOOD);
    s = done_seen0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 1; i < 100 && done_seen0 == s; i++) begin
      if (i == 5 || i == 20) start0 = 1'b1;
      tick();
      start0 = 1'b0;
    end
    check("repulse_timeout", 32'(done_seen0 - s), 32'd1);
    repeat (3) tick();
    check("repulse_no_restart", 32'(busy0), 32'd0);

    // Reset mid-sweep at vector 9 aborts with no done pulse.
    s = done_seen0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 40 && vec0 != 4'd9; i++) tick();
    check("abort_reached_vec9", 32'(vec0), 32'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset0("abort");
    repeat (3) tick();
    check("abort_no_done", 32'(done_seen0 - s), 32'd0);

    run0(0, E_GOOD);      // fresh sweep after abort

    check("dut0_pending", 32'(q0.size()), 32'd0);
    check("dut1_pending", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
